// File: rtl/sram_arb_pkg.sv
// Shared tag encoding and parameter bounds for the SRAM port arbiter.
package sram_arb_pkg;
  typedef logic [1:0] tag_t;

  localparam tag_t TAG_NONE = 2'd0;
  localparam tag_t TAG_INST = 2'd1;
  localparam tag_t TAG_DATA = 2'd2;

  localparam int RD_LAT_MIN   = 1;
  localparam int RD_LAT_MAX   = 4;
  localparam int STARVE_CNT_W = 4;
endpackage

// File: rtl/sram_arb_tagpipe.sv
// RD_LAT-deep shift register of read-owner tags; the last stage names the
// requester whose data is on mem_rdata this cycle.
module sram_arb_tagpipe
  import sram_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [RD_LAT-1:0] tag_q, tag_d;

  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = tag_in;
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tag_q <= {RD_LAT{TAG_NONE}};
    else      tag_q <= tag_d;
  end

  assign tag_out = tag_q[RD_LAT-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: data-over-fetch priority, tagged read returns.
// SRAM_ARB_STARVE_EN enables the bounded-starvation forced fetch grant.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stallreq_if,
  output logic              stallreq_mem
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("sram_port_arbiter: RD_LAT out of range");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("sram_port_arbiter: STARVE_MAX out of range");
  end

  logic inst_v, data_v, force_inst, inst_win, data_win;
  tag_t tag_in, tag_out;

  // Requests are masked during reset so every output reads 0 while held.
  assign inst_v = inst_req & rst;
  assign data_v = data_req & rst;

`ifdef SRAM_ARB_STARVE_EN
  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign force_inst = inst_v & (starve_cnt_q == STARVE_LIM);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (inst_win)                             starve_cnt_d = '0;
    else if (inst_v && starve_cnt_q != STARVE_LIM) starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_cnt_q <= '0;
    else      starve_cnt_q <= starve_cnt_d;
  end
`else
  assign force_inst = 1'b0;
`endif

  assign inst_win = inst_v & (~data_v | force_inst);
  assign data_win = data_v & ~inst_win;

  assign inst_gnt     = inst_win;
  assign data_gnt     = data_win;
  assign stallreq_if  = inst_v & ~inst_win;
  assign stallreq_mem = data_v & ~data_win;

  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_in    = TAG_NONE;
    if (inst_win) begin
      mem_en   = 1'b1;
      mem_addr = inst_addr;
      tag_in   = TAG_INST;
    end else if (data_win) begin
      mem_en    = 1'b1;
      mem_wen   = data_wen;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
      if (data_wen == 4'h0) tag_in = TAG_DATA;
    end
  end

  sram_arb_tagpipe #(.RD_LAT(RD_LAT)) u_tagpipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign inst_rvalid = (tag_out == TAG_INST);
  assign data_rvalid = (tag_out == TAG_DATA);
  assign inst_rdata  = inst_rvalid ? mem_rdata : '0;
  assign data_rdata  = data_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model.
module tb_sram_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RD_LAT = 3;
  localparam int STARVE_MAX = 4;
`ifdef SRAM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif
  localparam logic [31:0] RDATA_K = 32'hCAFEF00D;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          inst_req = 1'b0;
  logic [AW-1:0] inst_addr = '0;
  logic          inst_gnt, inst_rvalid;
  logic [DW-1:0] inst_rdata;
  logic          data_req = 1'b0;
  logic [3:0]    data_wen = 4'h0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic          data_gnt, data_rvalid;
  logic [DW-1:0] data_rdata;
  logic          mem_en;
  logic [3:0]    mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          stallreq_if, stallreq_mem;

  int checks = 0;
  int errors = 0;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Model: starvation count, and a per-cycle schedule of which requester
  // owns the read data returning that cycle (1=inst, 2=data).
  int cyc = 0;
  int scnt = 0;
  int exp_tag[int];
  bit m_ig = 0, m_dg = 0;

  always @(negedge clk) begin
    bit eig, edg, frc;
    int tg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    logic [3:0] ewe;
    if (!rst) begin
      scnt = 0;
      exp_tag.delete();
      eig = 0; edg = 0; tg = 0;
    end else begin
      frc = STARVE && (scnt == STARVE_MAX) && inst_req;
      eig = inst_req && (!data_req || frc);
      edg = data_req && !eig;
      tg  = exp_tag.exists(cyc) ? exp_tag[cyc] : 0;
    end
    ea = eig ? inst_addr : (edg ? data_addr : '0);
    ewe = edg ? data_wen : 4'h0;
    ewd = edg ? data_wdata : '0;
    chk("inst_gnt", inst_gnt, eig);
    chk("data_gnt", data_gnt, edg);
    chk("stallreq_if", stallreq_if, rst && inst_req && !eig);
    chk("stallreq_mem", stallreq_mem, rst && data_req && !edg);
    chk("mem_en", mem_en, eig || edg);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wen", mem_wen, ewe);
    chk("mem_wdata", mem_wdata, ewd);
    chk("inst_rvalid", inst_rvalid, tg == 1);
    chk("data_rvalid", data_rvalid, tg == 2);
    chk("inst_rdata", inst_rdata, (tg == 1) ? mem_rdata : '0);
    chk("data_rdata", data_rdata, (tg == 2) ? mem_rdata : '0);
    if (rst) begin
      if (exp_tag.exists(cyc)) exp_tag.delete(cyc);
      if (eig) exp_tag[cyc + RD_LAT] = 1;
      else if (edg && data_wen == 4'h0) exp_tag[cyc + RD_LAT] = 2;
      if (eig) scnt = 0;
      else if (inst_req && scnt < STARVE_MAX) scnt++;
    end
    m_ig = eig;
    m_dg = edg;
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ip, dp, exp_i;
    mem_rdata = RDATA_K;
    // Reset held with both requests up: everything quiet.
    inst_req = 1; data_req = 1; data_wen = 4'h0;
    inst_addr = 32'h1000; data_addr = 32'h2000; data_wdata = 32'h55AA55AA;
    repeat (3) step();
    #1;
    chk("rst_inst_gnt", inst_gnt, 0);
    chk("rst_data_gnt", data_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_stallreq_if", stallreq_if, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // Release: data wins immediately, then the contention pattern.
    step(); rst = 1; #1;
    chk("rel_data_gnt", data_gnt, 1);
    chk("rel_inst_gnt", inst_gnt, 0);
    chk("rel_stallreq_if", stallreq_if, 1);
    for (int k = 1; k < 6; k++) begin
      step(); #1;
      exp_i = STARVE && (k == 4);
      chk("cont_inst_gnt", inst_gnt, exp_i);
      chk("cont_data_gnt", data_gnt, !exp_i);
      chk("cont_stallreq_if", stallreq_if, !exp_i);
    end
    step(); data_req = 0;
    step(); inst_req = 0;
    repeat (RD_LAT + 2) step();

    // Lone fetch.
    inst_req = 1; inst_addr = 32'hBFC00000; data_wdata = 32'hDEADBEEF; #1;
    chk("fetch_gnt", inst_gnt, 1);
    chk("fetch_addr", mem_addr, 32'hBFC00000);
    chk("fetch_wen", mem_wen, 0);
    chk("fetch_wdata", mem_wdata, 0);
    for (int k = 1; k <= RD_LAT; k++) begin
      step();
      if (k == 1) inst_req = 0;
      #1;
      chk("fetch_rvalid", inst_rvalid, k == RD_LAT);
      if (k == RD_LAT) chk("fetch_rdata", inst_rdata, RDATA_K);
    end
    repeat (2) step();

    // Store then load at the same address.
    data_req = 1; data_wen = 4'hF; data_addr = 32'h100; data_wdata = 32'h12345678; #1;
    chk("st_gnt", data_gnt, 1);
    chk("st_wen", mem_wen, 4'hF);
    chk("st_wdata", mem_wdata, 32'h12345678);
    step(); data_wen = 4'h0; #1;
    chk("ld_gnt", data_gnt, 1);
    chk("ld_wen", mem_wen, 0);
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      step();
      if (k == 1) data_req = 0;
      #1;
      chk("ld_rvalid", data_rvalid, k == RD_LAT);
      if (k == RD_LAT) chk("ld_rdata", data_rdata, RDATA_K);
    end
    repeat (2) step();

    // Reset while a fetch is in flight: its response is dropped.
    inst_req = 1; inst_addr = 32'h40;
    step(); inst_req = 0; rst = 0;
    step(); rst = 1;
    for (int k = 0; k < RD_LAT + 2; k++) begin
      #1;
      chk("flush_inst_rvalid", inst_rvalid, 0);
      chk("flush_data_rvalid", data_rvalid, 0);
      step();
    end

    // Randomized traffic; requests are held until the model says granted.
    ip = 0; dp = 0;
    for (int n = 0; n < 3000; n++) begin
      step();
      mem_rdata = $urandom;
      if ($urandom_range(0, 199) == 0) rst = 0;
      else rst = 1;
      if (!ip || m_ig) begin
        ip = ($urandom_range(0, 2) != 0);
        inst_addr = $urandom;
      end
      if (!dp || m_dg) begin
        dp = ($urandom_range(0, 3) != 0);
        data_addr = $urandom;
        data_wdata = $urandom;
        data_wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      inst_req = ip;
      data_req = dp;
    end
    step(); rst = 1; inst_req = 0; data_req = 0;
    repeat (RD_LAT + 2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Arbitrates a single synchronous single-ported SRAM between the core's instruction-fetch requester and its data-access requester. Grants one access per cycle with data priority and bounded instruction starvation. Tracks in-flight reads so each read response returns to the requester that issued it. Raises per-requester stall requests that feed the pipeline stall controller.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RD_LAT, 1, SRAM read latency in cycles; legal range 1..4
- STARVE_MAX, 4, maximum consecutive denied instruction cycles before forced instruction grant; legal range 1..15

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- inst_req  in  1  fetch request; held stable until inst_gnt
- inst_addr  in  ADDR_W  fetch address
- inst_gnt  out  1  fetch accepted this cycle
- inst_rvalid  out  1  fetch data valid
- inst_rdata  out  DATA_W  fetch data
- data_req  in  1  data request; held stable until data_gnt
- data_wen  in  4  byte write enables; 0 = read
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_gnt  out  1  data access accepted this cycle
- data_rvalid  out  1  load data valid
- data_rdata  out  DATA_W  load data
- mem_en  out  1  SRAM enable
- mem_wen  out  4  SRAM byte write enables
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after mem_en
- stallreq_if  out  1  inst_req & ~inst_gnt
- stallreq_mem  out  1  data_req & ~data_gnt

## Operation
- Each cycle, at most one winner. Default priority: data over instruction.
- Starvation counter `starve_cnt` (4 bits):
  - increments each cycle inst_req=1 and inst_gnt=0
  - clears on inst_gnt
  - saturates at STARVE_MAX
- When starve_cnt==STARVE_MAX and inst_req=1, instruction wins over data.
- Winner drives mem_en=1, mem_addr, mem_wen, mem_wdata. Instruction accesses drive mem_wen=0 and mem_wdata=0. With no winner, all mem_* outputs are 0.
- Tag pipeline: RD_LAT-deep shift register of 2-bit tags (NONE/INST/DATA).
  - Stage 0 loads INST on an instruction grant, DATA on a data read grant (data_wen==0), and NONE otherwise.
  - Writes never produce rvalid.
- At the pipeline output:
  - tag INST → inst_rvalid=1.
  - tag DATA → data_rvalid=1.
  - inst_rdata and data_rdata both equal mem_rdata whenever their rvalid is set, else 0.
- Requester dropping its request before grant is a protocol violation; behaviour is unspecified.

## Timing
- Grants and mem_* outputs are combinational from requests and starve_cnt in the same cycle T.
- rvalid asserts at cycle T+RD_LAT, registered from the tag pipeline. A new access may issue every cycle, so reads can be back-to-back.
- Reset values:
  - all outputs 0
  - starve_cnt 0
  - every tag NONE
- Reset asserted mid-operation discards in-flight reads: no rvalid after rst deasserts for accesses issued before it.
- Simultaneous requests with starve_cnt<STARVE_MAX → data_gnt only, stallreq_if=1.

## Configuration
- SRAM_ARB_STARVE_EN defined:
  - starvation counter present
  - forced instruction grant behaves as above
- Not defined:
  - counter removed
  - fixed data priority
  - instruction may starve indefinitely
  - STARVE_MAX ignored

## Structure
- Package sram_arb_pkg holds:
  - tag encoding constants TAG_NONE=2'd0, TAG_INST=2'd1, TAG_DATA=2'd2
  - RD_LAT legal bounds
- Sub-module sram_arb_tagpipe holds the parameterised RD_LAT-deep tag shift register with asynchronous active-low clear.

## Test plan
- Reset: hold rst=0 with both requests high → all outputs 0. Release → data_gnt=1 same cycle.
- Lone fetch, RD_LAT=1: inst_req=1, inst_addr=0xBFC00000 → inst_gnt=1 and mem_addr=0xBFC00000 in T. inst_rvalid=1 in T+1 with mem_rdata forwarded.
- Contention, STARVE_MAX=4, macro defined: both requesters held for 6 cycles → data granted cycles 0–3, instruction granted cycle 4, data granted cycle 5. stallreq_if is high for cycles 0–3.
- Same contention stimulus, macro undefined → instruction never granted while data_req=1.
- Store then load, RD_LAT=2: store (data_wen=4'hF, wdata=0x12345678) then load at the same address → no rvalid for the store. data_rvalid asserts exactly 2 cycles after the load grant.
- Reset mid-flight, RD_LAT=3: issue a read, assert rst one cycle later, release → neither rvalid asserts.
